// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, issues single-outstanding imem requests, hands words to decode.
// Optional FETCH_STATS_EN adds saturating fetch/redirect event counters.
module fetch_seq #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            flush,
    output logic            misalign_trap
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_fetch_cnt,
    output logic [31:0]     stat_redirect_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_hit, redirect_mis;
    logic            inst_valid_nxt, flush_nxt, trap_nxt, capture;

    assign redirect_hit   = redirect_valid && (state != S_IDLE);
    assign redirect_mis   = redirect_target[1:0] != 2'b00;
    assign redirect_pc    = redirect_mis ? TRAP_VEC : redirect_target;
    assign imem_req_valid = (state == S_REQ);
    assign imem_addr      = pc;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // A redirect overrides every state's own pc/inst_valid update; only the
    // state transition still depends on where the in-flight request stands.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        inst_valid_nxt = inst_valid;
        capture        = 1'b0;
        flush_nxt      = redirect_hit;
        trap_nxt       = redirect_hit && redirect_mis;
        if (redirect_hit) begin
            pc_nxt         = redirect_pc;
            inst_valid_nxt = 1'b0;
        end
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ: begin
                if (imem_req_ready) state_nxt = redirect_hit ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (redirect_hit) begin
                    state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid) begin
                    capture        = 1'b1;
                    inst_valid_nxt = 1'b1;
                    pc_nxt         = pc + XLEN'(4);
                    state_nxt      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_hit || inst_ready) begin
                    inst_valid_nxt = 1'b0;
                    state_nxt      = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) state_nxt = S_REQ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_VEC;
            inst_valid    <= 1'b0;
            inst          <= '0;
            inst_pc       <= '0;
            flush         <= 1'b0;
            misalign_trap <= 1'b0;
        end else begin
            pc            <= pc_nxt;
            inst_valid    <= inst_valid_nxt;
            flush         <= flush_nxt;
            misalign_trap <= trap_nxt;
            if (capture) begin
                inst    <= imem_rsp_data;
                inst_pc <= pc;
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetch_cnt    <= '0;
            stat_redirect_cnt <= '0;
        end else begin
            if (inst_valid && inst_ready && stat_fetch_cnt != '1)
                stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
            if (redirect_valid && stat_redirect_cnt != '1)
                stat_redirect_cnt <= stat_redirect_cnt + 32'd1;
        end
    end
`else
    // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus random traffic against a
// transaction-level model (request outstanding / stale / instruction-held flags).
module tb_fetch_seq;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        flush;
    logic        misalign_trap;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetch_cnt;
    logic [31:0] stat_redirect_cnt;
`endif

    int assertions = 0;
    int failures   = 0;

    // Reference model state
    logic        m_started, m_out, m_stale, m_have, m_flush, m_trap;
    logic [31:0] m_pc, m_inst, m_inst_pc, m_fetch_cnt, m_redir_cnt;
    // Memory model state
    logic        mem_pending;
    int          mem_wait;
    int unsigned lat_lo = 1, lat_hi = 1;

    fetch_seq #(
        .XLEN      (32),
        .RESET_VEC (RESET_VEC),
        .TRAP_VEC  (TRAP_VEC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .flush           (flush),
        .misalign_trap   (misalign_trap)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetch_cnt    (stat_fetch_cnt),
        .stat_redirect_cnt (stat_redirect_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_started   = 1'b0;
        m_out       = 1'b0;
        m_stale     = 1'b0;
        m_have      = 1'b0;
        m_flush     = 1'b0;
        m_trap      = 1'b0;
        m_pc        = RESET_VEC;
        m_inst      = '0;
        m_inst_pc   = '0;
        m_fetch_cnt = '0;
        m_redir_cnt = '0;
        mem_pending = 1'b0;
        mem_wait    = 0;
    endtask

    // Drive one cycle of inputs (from a negedge), advance the model, wait for the next negedge.
    task automatic apply(input logic rv, input logic [31:0] tgt, input logic rdy, input logic ir);
        logic        rsp, req, accept, mis;
        logic [31:0] data;
        rsp  = mem_pending && (mem_wait == 0);
        data = $urandom();
        if (mem_pending && mem_wait > 0) mem_wait = mem_wait - 1;
        redirect_valid  = rv;
        redirect_target = tgt;
        imem_req_ready  = rdy;
        inst_ready      = ir;
        imem_rsp_valid  = rsp;
        imem_rsp_data   = data;
        if (rst) begin
            model_reset();
        end else begin
            req    = m_started && !m_out && !m_have;
            accept = req && rdy;
            if (m_have && ir && m_fetch_cnt != 32'hFFFF_FFFF) m_fetch_cnt = m_fetch_cnt + 1;
            if (rv && m_redir_cnt != 32'hFFFF_FFFF) m_redir_cnt = m_redir_cnt + 1;
            m_flush = 1'b0;
            m_trap  = 1'b0;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (rv) begin
                mis     = tgt[1:0] != 2'b00;
                m_flush = 1'b1;
                m_trap  = mis;
                m_pc    = mis ? TRAP_VEC : tgt;
                m_have  = 1'b0;
                if (accept) begin
                    m_out = 1'b1; m_stale = 1'b1;
                end else if (m_out && rsp) begin
                    m_out = 1'b0; m_stale = 1'b0;
                end else if (m_out) begin
                    m_stale = 1'b1;
                end
            end else begin
                if (accept) begin
                    m_out = 1'b1; m_stale = 1'b0;
                end else if (m_out && rsp) begin
                    if (!m_stale) begin
                        m_have    = 1'b1;
                        m_inst    = data;
                        m_inst_pc = m_pc;
                        m_pc      = m_pc + 32'd4;
                    end
                    m_out = 1'b0; m_stale = 1'b0;
                end else if (m_have && ir) begin
                    m_have = 1'b0;
                end
            end
            if (rsp) mem_pending = 1'b0;
            if (accept) begin
                mem_pending = 1'b1;
                mem_wait    = int'($urandom_range(lat_hi, lat_lo)) - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) apply(1'b0, '0, 1'b0, 1'b0);
        assertions++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        assertions++; if (imem_addr !== RESET_VEC) begin failures++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_VEC); end
        assertions++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        assertions++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h/%h want 0/0", inst, inst_pc); end
        assertions++; if (flush !== 1'b0 || misalign_trap !== 1'b0) begin failures++; $display("FAIL reset_pulses: got %b/%b want 0/0", flush, misalign_trap); end
        rst = 1'b0;
        apply(1'b0, '0, 1'b0, 1'b0);
        assertions++; if (imem_req_valid !== 1'b1 || imem_addr !== RESET_VEC) begin failures++; $display("FAIL first_req: got %b@%h want 1@%h", imem_req_valid, imem_addr, RESET_VEC); end
    endtask

    task automatic test_sequential();
        logic [31:0] seen[$];
        int          n_inst = 0;
        lat_lo = 1; lat_hi = 1;
        for (int c = 0; c < 40 && seen.size() < 3; c++) begin
            if (imem_req_valid === 1'b1) seen.push_back(imem_addr);
            if (inst_valid === 1'b1) begin
                assertions++;
                if (inst_pc !== 32'(4 * n_inst) || inst !== m_inst) begin
                    failures++; $display("FAIL seq_inst%0d: got %h@%h want %h@%h", n_inst, inst, inst_pc, m_inst, 32'(4 * n_inst));
                end
                n_inst++;
            end
            apply(1'b0, '0, 1'b1, 1'b1);
        end
        assertions++; if (seen.size() != 3) begin failures++; $display("FAIL seq_timeout: got %0d requests want 3", seen.size()); end
        for (int i = 0; i < seen.size(); i++) begin
            assertions++;
            if (seen[i] !== 32'(4 * i)) begin failures++; $display("FAIL seq_addr%0d: got %h want %h", i, seen[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] s_inst, s_pc;
        int          budget = 0;
        lat_lo = 1; lat_hi = 1;
        while (inst_valid !== 1'b1 && budget < 10) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            budget++;
        end
        assertions++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL stall_timeout: inst_valid got %b want 1", inst_valid); end
        s_inst = inst;
        s_pc   = inst_pc;
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            assertions++;
            if (inst_valid !== 1'b1 || inst !== s_inst || inst_pc !== s_pc || imem_req_valid !== 1'b0) begin
                failures++; $display("FAIL stall_hold%0d: got v=%b %h@%h req=%b want v=1 %h@%h req=0", i, inst_valid, inst, inst_pc, imem_req_valid, s_inst, s_pc);
            end
        end
        apply(1'b0, '0, 1'b0, 1'b1);
        assertions++;
        if (imem_req_valid !== 1'b1 || imem_addr !== s_pc + 32'd4 || inst_valid !== 1'b0) begin
            failures++; $display("FAIL stall_release: got req=%b@%h v=%b want req=1@%h v=0", imem_req_valid, imem_addr, inst_valid, s_pc + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] s_inst;
        s_inst = inst;
        lat_lo = 3; lat_hi = 3;
        apply(1'b0, '0, 1'b1, 1'b0);
        apply(1'b1, 32'h40, 1'b0, 1'b0);
        assertions++;
        if (flush !== 1'b1 || misalign_trap !== 1'b0 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            failures++; $display("FAIL redir_flush: got f=%b t=%b req=%b v=%b want 1 0 0 0", flush, misalign_trap, imem_req_valid, inst_valid);
        end
        apply(1'b0, '0, 1'b1, 1'b1);
        assertions++;
        if (flush !== 1'b0 || imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL redir_drain: got f=%b req=%b want 0 0", flush, imem_req_valid);
        end
        apply(1'b0, '0, 1'b0, 1'b1);
        assertions++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40 || inst_valid !== 1'b0 || inst !== s_inst) begin
            failures++; $display("FAIL redir_refetch: got req=%b@%h v=%b inst=%h want req=1@00000040 v=0 inst=%h", imem_req_valid, imem_addr, inst_valid, inst, s_inst);
        end
    endtask

    task automatic test_misalign();
        apply(1'b1, 32'h42, 1'b0, 1'b0);
        assertions++;
        if (flush !== 1'b1 || misalign_trap !== 1'b1 || imem_req_valid !== 1'b1 || imem_addr !== TRAP_VEC) begin
            failures++; $display("FAIL misalign_pulse: got f=%b t=%b req=%b@%h want 1 1 1@%h", flush, misalign_trap, imem_req_valid, imem_addr, TRAP_VEC);
        end
        apply(1'b0, '0, 1'b0, 1'b0);
        assertions++;
        if (flush !== 1'b0 || misalign_trap !== 1'b0 || imem_addr !== TRAP_VEC) begin
            failures++; $display("FAIL misalign_once: got f=%b t=%b addr=%h want 0 0 %h", flush, misalign_trap, imem_addr, TRAP_VEC);
        end
    endtask

    task automatic test_wrap();
        lat_lo = 1; lat_hi = 1;
        apply(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        assertions++;
        if (imem_addr !== 32'hFFFF_FFFC || misalign_trap !== 1'b0) begin
            failures++; $display("FAIL wrap_target: got %h t=%b want fffffffc t=0", imem_addr, misalign_trap);
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        apply(1'b0, '0, 1'b0, 1'b0);
        assertions++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_inst: got v=%b pc=%h want v=1 pc=fffffffc", inst_valid, inst_pc);
        end
        apply(1'b0, '0, 1'b0, 1'b1);
        assertions++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            failures++; $display("FAIL wrap_next: got req=%b@%h want req=1@00000000", imem_req_valid, imem_addr);
        end
    endtask

    task automatic test_reset_in_drain();
        lat_lo = 3; lat_hi = 3;
        apply(1'b0, '0, 1'b1, 1'b0);
        apply(1'b1, 32'h80, 1'b0, 1'b0);
        rst = 1'b1;
        apply(1'b0, '0, 1'b0, 1'b0);
        assertions++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 ||
            flush !== 1'b0 || misalign_trap !== 1'b0 || imem_addr !== RESET_VEC) begin
            failures++; $display("FAIL drain_reset: got req=%b v=%b %h@%h f=%b t=%b addr=%h want all reset values", imem_req_valid, inst_valid, inst, inst_pc, flush, misalign_trap, imem_addr);
        end
        rst = 1'b0;
        apply(1'b0, '0, 1'b0, 1'b0);
        assertions++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RESET_VEC) begin
            failures++; $display("FAIL drain_refetch: got req=%b@%h want req=1@%h", imem_req_valid, imem_addr, RESET_VEC);
        end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        int budget = 0;
        lat_lo = 1; lat_hi = 1;
        rst = 1'b1;
        apply(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        while (m_fetch_cnt != 32'd3 && budget < 40) begin
            apply(1'b0, '0, 1'b1, 1'b1);
            budget++;
        end
        apply(1'b1, 32'h200, 1'b0, 1'b0);
        assertions++;
        if (stat_fetch_cnt !== 32'd3 || stat_redirect_cnt !== 32'd1) begin
            failures++; $display("FAIL stats_count: got %0d/%0d want 3/1", stat_fetch_cnt, stat_redirect_cnt);
        end
        rst = 1'b1;
        apply(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        assertions++;
        if (stat_fetch_cnt !== 32'd0 || stat_redirect_cnt !== 32'd0) begin
            failures++; $display("FAIL stats_clear: got %0d/%0d want 0/0", stat_fetch_cnt, stat_redirect_cnt);
        end
    endtask
`endif

    task automatic test_random();
        logic        rv, rdy, ir, req;
        logic [31:0] tgt;
        int unsigned sel;
        lat_lo = 1; lat_hi = 3;
        for (int c = 0; c < 800; c++) begin
            req = m_started && !m_out && !m_have;
            assertions++;
            if (imem_req_valid !== req || (req && imem_addr !== m_pc)) begin
                failures++; $display("FAIL rnd_req c%0d: got %b@%h want %b@%h", c, imem_req_valid, imem_addr, req, m_pc);
            end
            assertions++;
            if (inst_valid !== m_have || inst !== m_inst || inst_pc !== m_inst_pc) begin
                failures++; $display("FAIL rnd_inst c%0d: got v=%b %h@%h want v=%b %h@%h", c, inst_valid, inst, inst_pc, m_have, m_inst, m_inst_pc);
            end
            assertions++;
            if (flush !== m_flush || misalign_trap !== m_trap) begin
                failures++; $display("FAIL rnd_pulse c%0d: got f=%b t=%b want f=%b t=%b", c, flush, misalign_trap, m_flush, m_trap);
            end
`ifdef FETCH_STATS_EN
            assertions++;
            if (stat_fetch_cnt !== m_fetch_cnt || stat_redirect_cnt !== m_redir_cnt) begin
                failures++; $display("FAIL rnd_stats c%0d: got %0d/%0d want %0d/%0d", c, stat_fetch_cnt, stat_redirect_cnt, m_fetch_cnt, m_redir_cnt);
            end
`endif
            rv  = $urandom_range(0, 9) == 0;
            rdy = $urandom_range(0, 2) != 0;
            ir  = $urandom_range(0, 2) != 0;
            sel = $urandom_range(0, 7);
            if (sel == 0)      tgt = 32'hFFFF_FFFC;
            else if (sel == 1) tgt = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else               tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            rst = ($urandom_range(0, 199) == 0);
            apply(rv, tgt, rdy, ir);
            rst = 1'b0;
        end
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_misalign();
        test_wrap();
        test_reset_in_drain();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
